serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial adder. It adds two WIDTH-bit operands plus a carry-in over WIDTH clock cycles, LSB first, and retires one result bit per cycle through a single FULLADDER cell and a carry flip-flop. It sits in the adder family as the area-minimal, multi-cycle counterpart to the combinational ripple adders. It uses a start/done handshake toward the datapath controller.

## Interface
- WIDTH, 8: operand and result width in bits; legal range ≥2.
- clk  in  1: sole clock; all state updates on its rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- start  in  1: request; sampled only when busy==0.
- in1  in  WIDTH: operand A; captured on the accepted start.
- in2  in  WIDTH: operand B; captured on the accepted start.
- carryIn  in  1: initial carry; captured on the accepted start.
- sub  in  1: present only with SERIAL_ADDER_SUB_EN; selects subtract; captured on the accepted start.
- busy  out  1: high while in RUN.
- done  out  1: one-cycle pulse when the result is valid.
- out  out  WIDTH: sum; held stable from done until the next accepted start.
- carryOut  out  1: final carry; held with out.
- overflow  out  1: signed overflow (carry into MSB XOR carry out of MSB); held with out.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE when bit counter == WIDTH-1.
  - DONE→RUN on start; DONE→IDLE otherwise.
- Accepting start (IDLE or DONE) has these effects:
  - opA←in1, opB←in2, carry←carryIn, cnt←0.
  - out, carryOut and overflow keep their old values until the new result completes.
- Each RUN cycle:
  - FULLADDER(carry, opA[0], opB[0]) produces sum s and carry c.
  - res shifts right with s inserted at bit WIDTH-1; opA and opB shift right; carry←c; cnt←cnt+1.
  - On the final bit, the carry into the MSB (the pre-update carry) is also saved for the overflow computation.
- On the RUN→DONE edge:
  - out←final res; carryOut←final c; overflow←(carry into MSB) XOR c.
  - done is asserted for the DONE cycle only.
- start is ignored while busy==1. No queueing; the requester must wait for done.
- Counter width is $clog2(WIDTH). It never wraps because the FSM leaves RUN at WIDTH-1.

## Timing
- Reset values: state=IDLE; busy=0; done=0; out=0; carryOut=0; overflow=0; internal registers 0.
- Latency: start accepted at edge k; RUN occupies edges k+1..k+WIDTH; done is high in the cycle after edge k+WIDTH.
  - start→done = WIDTH+1 cycles.
  - Back-to-back throughput is one result per WIDTH+1 cycles.
- start sampled in the DONE cycle begins the next operation. done still pulses for the old result in that cycle.
- Reset mid-RUN aborts the operation and all outputs return to reset values. No partial result appears.
- Reset and start asserted in the same cycle: reset wins.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - When sub=1 at start: opB←~in2, carry←1, and carryIn is ignored.
  - carryOut=1 means no borrow. overflow is the signed subtract overflow.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port and no inversion logic.
  - The block always adds.

## Structure
- Shared package adder_pkg holds:
  - The state enum typedef (IDLE, RUN, DONE).
  - The default WIDTH constant.
- Sub-module: the existing gate-level FULLADDER, instantiated once as the per-bit core. No other sub-modules.

## Test plan
All scenarios use WIDTH=8.
- 0x00+0x00, carryIn=0 → done exactly 9 cycles after start; out=0x00, carryOut=0, overflow=0; busy high for cycles 1–8.
- 0xFF+0x01, carryIn=0 → out=0x00, carryOut=1, overflow=0.
- 0x7F+0x01, carryIn=0 → out=0x80, carryOut=0, overflow=1. Then 0x0F+0x10 with carryIn=1 → out=0x20, carryOut=0.
- start pulsed again during RUN → ignored; first result correct. Then start in the DONE cycle → second operation begins immediately; its done follows 8 cycles after that DONE cycle.
- Reset asserted after 3 RUN cycles of 0xAA+0x55 → busy=0, done=0, out=0x00 at once. No done pulse follows. The next operation 0x01+0x02 → out=0x03.
- With SERIAL_ADDER_SUB_EN, sub=1: 0x05-0x07 → out=0xFE, carryOut=0, overflow=0. And 0x80-0x01 → out=0x7F, carryOut=1, overflow=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: serial FSM state encoding and default width.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/FULLADDER.sv
// Gate-level one-bit full adder; the per-bit core of the serial adder.
module FULLADDER (
    input  logic cin,
    input  logic a,
    input  logic b,
    output logic s,
    output logic cout
);

    logic axb_s;

    assign axb_s = a ^ b;
    assign s     = axb_s ^ cin;
    assign cout  = (a & b) | (cin & axb_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one FULLADDER retires one result bit per cycle, LSB first.
// Optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carryIn,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carryOut,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_c;
    logic             accept_s;
    logic [WIDTH-1:0] opb_load_s;
    logic             carry_load_s;

    FULLADDER u_fa (
        .cin  (carry_q),
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign accept_s = start & ((state_q == IDLE) | (state_q == DONE));

    // Operand B and initial carry as loaded on an accepted start
    always_comb begin
        opb_load_s   = in2;
        carry_load_s = carryIn;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            opb_load_s   = ~in2;
            carry_load_s = 1'b1;
        end else begin
            opb_load_s   = in2;
            carry_load_s = carryIn;
        end
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_d = RUN;
                    opa_d   = in1;
                    opb_d   = opb_load_s;
                    carry_d = carry_load_s;
                    res_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                opa_d   = {1'b0, opa_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                carry_d = fa_c;
                if (cnt_q == CNT_LAST) begin
                    // carry_q here is the carry into the MSB
                    state_d = DONE;
                    cnt_d   = cnt_q;
                    out_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                end else begin
                    state_d = RUN;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign out      = out_q;
    assign carryOut = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       carryIn;
    logic       sub;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic       carryOut;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in1      (in1),
        .in2      (in2),
        .carryIn  (carryIn),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .out      (out),
        .carryOut (carryOut),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation; returns edges until done, busy-cycle count and out at edge 4.
    // poke>0 re-pulses start with junk operands on that edge count.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic s, input int poke,
                          output int lat, output int busy_cnt, output logic [7:0] out_mid);
        @(negedge clk);
        in1 = a; in2 = b; carryIn = ci; sub = s; start = 1'b1;
        lat = 0; busy_cnt = 0; out_mid = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
            if (lat == 4) out_mid = out;
            if (lat == poke) begin
                start = 1'b1; in1 = 8'hC3; in2 = 8'h3C; carryIn = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        start = 1'b0;
    endtask

    int         lat;
    int         bcnt;
    int         seen;
    logic [7:0] mid;

    initial begin
        reset = 1'b1; start = 1'b0; in1 = 8'h00; in2 = 8'h00; carryIn = 1'b0; sub = 1'b0;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_out", {24'd0, out}, 32'h00);
        check_eq("rst_cout", {31'd0, carryOut}, 32'd0);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(8'h00, 8'h00, 1'b0, 1'b0, 0, lat, bcnt, mid);
        check_eq("zero_lat", lat, 32'd9);
        check_eq("zero_busy", bcnt, 32'd8);
        check_eq("zero_out", {24'd0, out}, 32'h00);
        check_eq("zero_cout", {31'd0, carryOut}, 32'd0);
        check_eq("zero_ovf", {31'd0, overflow}, 32'd0);

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, lat, bcnt, mid);
        check_eq("ff1_out", {24'd0, out}, 32'h00);
        check_eq("ff1_cout", {31'd0, carryOut}, 32'd1);
        check_eq("ff1_ovf", {31'd0, overflow}, 32'd0);

        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, lat, bcnt, mid);
        check_eq("7f1_out", {24'd0, out}, 32'h80);
        check_eq("7f1_cout", {31'd0, carryOut}, 32'd0);
        check_eq("7f1_ovf", {31'd0, overflow}, 32'd1);

        run_op(8'h0F, 8'h10, 1'b1, 1'b0, 0, lat, bcnt, mid);
        check_eq("cin_out", {24'd0, out}, 32'h20);
        check_eq("cin_cout", {31'd0, carryOut}, 32'd0);
        check_eq("cin_ovf", {31'd0, overflow}, 32'd0);
        check_eq("cin_mid_hold", {24'd0, mid}, 32'h80);
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_hold_out", {24'd0, out}, 32'h20);
        check_eq("idle_done_low", {31'd0, done}, 32'd0);

        run_op(8'h12, 8'h34, 1'b0, 1'b0, 3, lat, bcnt, mid);
        check_eq("poke_lat", lat, 32'd9);
        check_eq("poke_out", {24'd0, out}, 32'h46);
        check_eq("poke_done", {31'd0, done}, 32'd1);

        // start lands in the DONE cycle of the previous result
        run_op(8'h21, 8'h43, 1'b0, 1'b0, 0, lat, bcnt, mid);
        check_eq("b2b_lat", lat, 32'd9);
        check_eq("b2b_mid_hold", {24'd0, mid}, 32'h46);
        check_eq("b2b_out", {24'd0, out}, 32'h64);

        @(negedge clk);
        in1 = 8'hAA; in2 = 8'h55; carryIn = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_out", {24'd0, out}, 32'h00);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check_eq("abort_no_done", seen, 32'd0);

        run_op(8'h01, 8'h02, 1'b0, 1'b0, 0, lat, bcnt, mid);
        check_eq("post_lat", lat, 32'd9);
        check_eq("post_out", {24'd0, out}, 32'h03);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, lat, bcnt, mid);
        check_eq("sub57_out", {24'd0, out}, 32'hFE);
        check_eq("sub57_cout", {31'd0, carryOut}, 32'd0);
        check_eq("sub57_ovf", {31'd0, overflow}, 32'd0);

        run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, lat, bcnt, mid);
        check_eq("sub801_out", {24'd0, out}, 32'h7F);
        check_eq("sub801_cout", {31'd0, carryOut}, 32'd1);
        check_eq("sub801_ovf", {31'd0, overflow}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
